// File: rtl/tile_feed_scheduler_pkg.sv
// Shared definitions for the tile feed path: FSM encoding and default lane geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tile_feed_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fsm_state_t;

  // Geometry shared with the skew stage and the 8x8 array.
  localparam int unsigned WL_DEFAULT    = 8;
  localparam int unsigned LANES_DEFAULT = 8;

endpackage

// File: rtl/tile_feed_scheduler_valid_skew_chain.sv
// Purpose: DEPTH-deep 1-bit delay line; taps[k] is din delayed k+1 cycles.
// Latency: 1 cycle to taps[0], DEPTH cycles to taps[DEPTH-1].
// Backpressure: none; shifts every cycle, clr empties the whole line at the next edge.
module valid_skew_chain
  import tile_feed_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH = LANES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             din,
  output logic [DEPTH-1:0] taps
);

  logic [DEPTH-1:0] taps_q;
  logic [DEPTH-1:0] taps_d;

  // Shift one position per cycle, or flush everything on clear.
  always_comb begin
    taps_d = {taps_q[DEPTH-2:0], din};
    if (clr) begin
      taps_d = '0;
    end
  end

  // Delay-line storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      taps_q <= '0;
    end else begin
      taps_q <= taps_d;
    end
  end

  assign taps = taps_q;

endmodule

// File: rtl/tile_feed_scheduler.sv
// Purpose: streams one activation tile from SRAM into the lane skew stage with per-lane valids.
// Latency: first read 1 cycle after start; done pulses L+LANES+1 cycles after start.
// Backpressure: none; reads are contiguous, abort stops reads combinationally and flushes valids.
module tile_feed_scheduler
  import tile_feed_scheduler_pkg::*;
#(
  parameter int unsigned WL    = WL_DEFAULT,
  parameter int unsigned LANES = LANES_DEFAULT,
  parameter int unsigned AW    = 10,
  parameter int unsigned LW    = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [AW-1:0]         base_addr,
  input  logic [LW-1:0]         num_vec,
  output logic                  sram_rd_en,
  output logic [AW-1:0]         sram_addr,
  input  logic [LANES*WL-1:0]   sram_rdata,
  output logic [LANES*WL-1:0]   d_out,
  output logic [LANES-1:0]      lane_valid,
  output logic                  busy,
  output logic                  done
);

  fsm_state_t    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] num_q, num_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          rdata_valid;

  // Next-state, address and vector-count logic; abort overrides every state.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (num_vec != '0) begin
            state_d = ST_FETCH;
            addr_d  = base_addr;
            num_d   = num_vec;
            cnt_d   = '0;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_FETCH: begin
        addr_d = addr_q + AW'(1);
        cnt_d  = cnt_q + LW'(1);
        if (cnt_q == num_q - LW'(1)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Lanes 0..LANES-2 empty now means the last lane empties at this edge.
        if (lane_valid[LANES-2:0] == '0) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
    busy_d = (state_d == ST_FETCH) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
  end

  // FSM and tile-parameter registers with registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      num_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Stage 0 of the chain is the SRAM return-valid; stage k lines up with skew lane k.
  valid_skew_chain #(
    .DEPTH (LANES)
  ) u_valid_chain (
    .clk  (clk),
    .rst  (rst),
    .clr  (abort),
    .din  (sram_rd_en),
    .taps (lane_valid)
  );

  assign rdata_valid = lane_valid[0];
  assign sram_rd_en  = (state_q == ST_FETCH) && !abort;
  assign sram_addr   = addr_q;
  assign d_out       = rdata_valid ? sram_rdata : '0;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: doc/tile_feed_scheduler.md
Name: tile_feed_scheduler

Overview:
- Sequences one input-activation tile into the 8-lane skew register stage that feeds the 8x8 weight-stationary array.
- Issues consecutive activation-SRAM reads and presents each returned vector to the skew stage inputs.
- Generates per-lane valid bits delayed to match each lane's skew depth.
- Keeps running after the last read until the skew stage has drained, then signals done.

Parameters:
- WL, 8, bits per lane element
- LANES, 8, lane count; lane k has k cycles of skew delay downstream
- AW, 10, SRAM address width
- LW, 10, width of the vector-count field

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- start  input  1  begin a tile; sampled only in IDLE
- abort  input  1  synchronous abort; returns to IDLE with no done
- base_addr  input  AW  first SRAM address of the tile; captured at start
- num_vec  input  LW  number of vectors in the tile; captured at start
- sram_rd_en  output  1  SRAM read strobe
- sram_addr  output  AW  SRAM read address
- sram_rdata  input  LANES*WL  read data, valid exactly 1 cycle after sram_rd_en
- d_out  output  LANES*WL  to skew stage inputs; lane k is bits [k*WL +: WL]
- lane_valid  output  LANES  bit k high when skew-stage lane k output carries real data
- busy  output  1  high in FETCH and DRAIN
- done  output  1  one-cycle pulse at tile completion

Behaviour:
- Reset (rst=0, asynchronous): all registered outputs are 0, FSM=IDLE, vector counter=0, valid pipeline=0. No reads are issued until rst=1.
- FSM states: IDLE, FETCH, DRAIN, DONE.
- IDLE:
  - On start=1 with num_vec>0: capture base_addr and num_vec, go to FETCH.
  - On start=1 with num_vec=0: go to DONE; no reads are issued.
- FETCH:
  - sram_rd_en=1 every cycle.
  - sram_addr = captured base + i for i = 0..L-1, one per cycle, no gaps.
  - Address arithmetic is modulo 2^AW and wraps silently.
  - After the read with i=L-1, go to DRAIN.
- rdata_valid: sram_rd_en registered once.
- d_out = sram_rdata when rdata_valid=1, else all zeros. This is a combinational mask, so the skew stage shifts in zeros during bubbles and drain.
- lane_valid:
  - lane_valid[0] = rdata_valid.
  - lane_valid[k] = rdata_valid delayed k cycles, built from a LANES-1 deep shift chain.
  - This timing matches skew-stage lane outputs exactly.
- DRAIN:
  - Remain until the valid chain is all zero, i.e. LANES cycles after the last rd_en cycle.
  - Then go to DONE.
- DONE: done=1 for one cycle, busy=0, go to IDLE.
- Timeline, with the last read at cycle T:
  - rdata_valid at T+1.
  - lane_valid[LANES-1] last high at T+LANES.
  - done at T+LANES+1.
- Latency from start (cycle S) to done: S+L+LANES+1. For L=4 and LANES=8, done is at S+13.
- start while busy or in DONE: ignored; parameters are not re-captured.
- abort=1 in any state:
  - Next state is IDLE.
  - sram_rd_en drops in the same cycle (combinational gate).
  - Valid chain and rdata_valid are cleared at the next edge; no done pulse.
  - abort has priority over start in the same cycle.
- Reset mid-tile: immediate return to reset values; the in-flight SRAM response is discarded (rdata_valid=0).
- There is no backpressure: the skew stage shifts every cycle, so the tile is streamed contiguously.

Decomposition:
- Shared package:
  - FSM state encoding (2-bit: IDLE=0, FETCH=1, DRAIN=2, DONE=3).
  - Default constants WL=8 and LANES=8, shared with the skew stage and array.
- One sub-module, valid_skew_chain: a parameterised LANES-deep 1-bit delay line with async active-low reset and synchronous clear. It produces lane_valid from rdata_valid.
- Counter, address generator and FSM stay in the top module.

Test Plan:
- Basic tile: base_addr=0x010, num_vec=4, start pulsed at cycle 0.
  - Expect rd_en on cycles 1-4 with addr 0x010-0x013.
  - Expect lane_valid[0] on cycles 2-5 and lane_valid[7] on cycles 9-12.
  - Expect done at cycle 13; busy on cycles 1-12.
- Empty tile: num_vec=0, start.
  - Expect no rd_en, done one cycle later, busy never high.
- Address wrap: base_addr=0x3FE, num_vec=4.
  - Expect addresses 0x3FE, 0x3FF, 0x000, 0x001.
  - d_out lanes must equal the model SRAM data 1 cycle after each read.
- Abort: abort pulsed during FETCH after 2 reads of a num_vec=6 tile.
  - rd_en must stop in the same cycle and no done pulse may occur.
  - lane_valid must be all 0 from the next edge; a following start must work normally.
- Ignored start and reset: a second start pulsed during DRAIN must be ignored, with exactly one done.
  - Then assert rst=0 asynchronously mid-FETCH.
  - All outputs must be 0 immediately, and the FSM must be in IDLE after rst=1.
- Skew alignment: drive SRAM data lane k = 8'hA0+i for vector i, and feed d_out through the skew stage model.
  - Every lane output with lane_valid[k]=1 must equal the expected vector element.
  - Every lane output with lane_valid[k]=0 must be 0.
